tb_stimchk: RTL and testbench
=============================

TB_STIMCHK -- requirements
Module: tb_stimchk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of stimulus and checked data (2..32).
REQ-002 SHALL have parameter LATENCY, default 1: clock-cycle latency of the DUT pipeline under test (0..16).
REQ-003 SHALL have parameter ERRCNT_WIDTH, default 16: width of mismatch counter.
REQ-004 SHALL have parameter LFSR_TAPS, default 8'hB8 (zero-extended to DATA_WIDTH): Galois LFSR feedback mask.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1: advance generator this cycle.
REQ-008 SHALL have port mode, input, 1: 0 = incrementing counter, 1 = LFSR.
REQ-009 SHALL have port stim, output, DATA_WIDTH: registered stimulus to DUT input.
REQ-010 SHALL have port resp, input, DATA_WIDTH: DUT output.
REQ-011 SHALL have port armed, output, 1: checker comparing this cycle.
REQ-012 SHALL have port err, output, 1: single-cycle mismatch pulse.
REQ-013 SHALL have port err_cnt, output, ERRCNT_WIDTH: saturating mismatch count.
REQ-014 SHALL have ports first_err_vld (1), first_err_exp (DATA_WIDTH), first_err_got (DATA_WIDTH), outputs: first-mismatch capture.

Function
REQ-015 SHALL update stim each clock with en=1: mode 0 -> stim+1 modulo 2^DATA_WIDTH; mode 1 -> Galois step (shift right, XOR LFSR_TAPS if shifted-out LSB=1).
REQ-016 SHALL hold stim when en=0.
REQ-017 SHALL, in mode 1, load stim with 1 instead of stepping if stim is 0 (lockup escape), and otherwise step from the current stim value with no reseed on mode change.
REQ-018 SHALL apply mode changes on the first rising edge at which the new mode is sampled, with no idle cycle.
REQ-019 SHALL keep an expected-data delay line of LATENCY stages shifting stim every clock regardless of en; for LATENCY=0, expected equals current stim (combinational).
REQ-020 SHALL hold a warm-up counter that holds armed=0 for LATENCY clocks after reset release and drives armed=1 thereafter until the next reset.
REQ-021 SHALL, when armed=1 and resp != expected, assert err for exactly that cycle (registered; err visible the following cycle) and increment err_cnt.
REQ-022 SHALL saturate err_cnt at all-ones; further mismatches still pulse err.
REQ-023 SHALL never flag mismatches while armed=0.
REQ-024 SHALL capture expected and resp into first_err_exp/first_err_got on the first mismatch, set first_err_vld, and freeze all three until reset.

Reset
REQ-025 SHALL drive stim=0, err=0, err_cnt=0, armed=0, delay line all 0, warm-up counter 0, first_err_* 0 while rst_n=0.
REQ-026 SHALL, on reset assertion mid-run, clear state immediately (asynchronously) and restart warm-up on release.

Configuration
REQ-027 SHALL compile the first-error capture only when macro TB_STIMCHK_FIRST_ERR_EN is defined.
REQ-028 SHALL, without TB_STIMCHK_FIRST_ERR_EN, keep the first_err_* ports and tie them to constant 0; err/err_cnt remain unaffected.

Verification
REQ-029 SHALL cover: DATA_WIDTH=8, mode=0, en=1, resp=stim delayed 1 clock -> stim 0,1,2,...,FF,0; armed after 1 clock; err_cnt stays 0.
REQ-030 SHALL cover: mode=1 from stim=0 -> next stim 1, then 0xB8, 0x5C, 0x2E; 255 distinct nonzero values per period.
REQ-031 SHALL cover: LATENCY=3, resp forced to stim^1 for one cycle after arming -> one err pulse, err_cnt=1, first_err_exp/got capture that pair (macro on) or 0 (macro off).
REQ-032 SHALL cover: en=0 for 5 clocks -> stim holds, delay line fills with the held value, no errors with a correct DUT model.
REQ-033 SHALL cover: ERRCNT_WIDTH=4, persistent mismatch for 20 clocks -> err_cnt saturates at 15, err pulses every cycle.
REQ-034 SHALL cover: rst_n low mid-run -> all outputs 0 within the reset cycle, armed rises LATENCY clocks after release.

Source files
------------

// File: rtl/tb_stimchk.sv
// tb_stimchk: stimulus generator plus delayed-response checker for a DUT
// pipeline of fixed latency. The generator produces either an incrementing
// count or a Galois LFSR sequence. The checker compares the DUT response
// against a delayed copy of that stimulus and counts mismatches.
// Optional feature macro: TB_STIMCHK_FIRST_ERR_EN (first-mismatch capture).
module tb_stimchk #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          LATENCY      = 1,
  parameter int          ERRCNT_WIDTH = 16,
  parameter logic [31:0] LFSR_TAPS    = 32'h0000_00B8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  output logic [DATA_WIDTH-1:0]   stim,
  input  logic [DATA_WIDTH-1:0]   resp,
  output logic                    armed,
  output logic                    err,
  output logic [ERRCNT_WIDTH-1:0] err_cnt,
  output logic                    first_err_vld,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_got
);

  localparam logic [DATA_WIDTH-1:0] TAPS = LFSR_TAPS[DATA_WIDTH-1:0];
  // Warm-up counter only needs to reach LATENCY.
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  logic [DATA_WIDTH-1:0] expected;
  logic [CW-1:0]         wcnt;
  logic                  mismatch;

  // Stimulus generator: count or Galois LFSR step; an all-zero LFSR state
  // is escaped by loading 1, since zero would otherwise lock the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim <= '0;
    end else if (en) begin
      if (mode) begin
        if (stim == '0) stim <= DATA_WIDTH'(1);
        else            stim <= (stim >> 1) ^ (stim[0] ? TAPS : '0);
      end else begin
        stim <= stim + 1'b1;
      end
    end
  end

  // Expected-data delay line; runs every clock so a held stimulus fills it.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign expected = stim;
    end else begin : g_dly
      logic [LATENCY-1:0][DATA_WIDTH-1:0] dly;
      // Shift the current stimulus into stage 0 each cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly <= '0;
        end else begin
          dly[0] <= stim;
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign expected = dly[LATENCY-1];
    end
  endgenerate

  // Warm-up: arm once LATENCY edges have elapsed since reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      wcnt <= wcnt + 1'b1;
      if (int'(wcnt) + 1 >= LATENCY) armed <= 1'b1;
    end
  end

  assign mismatch = armed && (resp != expected);

  // Registered mismatch pulse and saturating mismatch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= mismatch;
      if (mismatch && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef TB_STIMCHK_FIRST_ERR_EN
  // First mismatch is captured once and frozen until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_vld <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_exp <= expected;
      first_err_got <= resp;
    end
  end
`else
  assign first_err_vld = 1'b0;
  assign first_err_exp = '0;
  assign first_err_got = '0;
`endif

endmodule

// File: tb/tb_tb_stimchk.sv
// Scoreboard bench for tb_stimchk. Two instances: A (LATENCY=1, 16-bit
// counter) and B (LATENCY=3, 4-bit counter). The stimulus process drives
// inputs on the falling edge, advances a behavioural model and queues the
// outputs expected after the next rising edge; the monitor pops and compares.
module tb_tb_stimchk;

  localparam int DW = 8;
  localparam int LAT  [2] = '{1, 3};
  localparam int CMAX [2] = '{65535, 15};
`ifdef TB_STIMCHK_FIRST_ERR_EN
  localparam bit FE_ON = 1'b1;
`else
  localparam bit FE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [DW-1:0] resp   [2];
  logic [DW-1:0] stim_o [2];
  logic          armed_o[2];
  logic          err_o  [2];
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;
  logic          fv_o   [2];
  logic [DW-1:0] fe_o   [2];
  logic [DW-1:0] fg_o   [2];

  always #5 clk = ~clk;

  tb_stimchk #(.DATA_WIDTH(DW), .LATENCY(1), .ERRCNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .stim(stim_o[0]), .resp(resp[0]), .armed(armed_o[0]), .err(err_o[0]),
    .err_cnt(cnt_a), .first_err_vld(fv_o[0]), .first_err_exp(fe_o[0]),
    .first_err_got(fg_o[0]));

  tb_stimchk #(.DATA_WIDTH(DW), .LATENCY(3), .ERRCNT_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .stim(stim_o[1]), .resp(resp[1]), .armed(armed_o[1]), .err(err_o[1]),
    .err_cnt(cnt_b), .first_err_vld(fv_o[1]), .first_err_exp(fe_o[1]),
    .first_err_got(fg_o[1]));

  typedef struct {
    int inst; int stim; int armed; int err; int cnt; int fv; int fe; int fg;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model state: stimulus, edges since reset release, stimulus history.
  int m_stim[2], m_k[2], m_err[2], m_cnt[2], m_fv[2], m_fe[2], m_fg[2];
  int hist[2][32];

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Value the checker should expect now: the stimulus LAT edges ago, or 0
  // if fewer edges than that have passed since reset.
  function automatic int cur_exp(input int i);
    return (m_k[i] >= LAT[i]) ? hist[i][(m_k[i] - LAT[i]) % 32] : 0;
  endfunction

  function automatic int next_stim(input int s, input bit md);
    if (!md) return (s + 1) % 256;
    if (s == 0) return 1;
    return (s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
  endfunction

  task automatic model_step(input int i, input bit r, input bit e, input bit md, input int rsp);
    exp_t x;
    if (!r) begin
      m_stim[i] = 0; m_k[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      m_fv[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
    end else begin
      int  ex;
      bit  arm, mis;
      ex  = cur_exp(i);
      arm = (m_k[i] >= 1) && (m_k[i] >= LAT[i]);
      mis = arm && (rsp != ex);
      m_err[i] = mis;
      if (mis) begin
        if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
        if (m_fv[i] == 0) begin m_fv[i] = 1; m_fe[i] = ex; m_fg[i] = rsp; end
      end
      hist[i][m_k[i] % 32] = m_stim[i];
      m_k[i]++;
      if (e) m_stim[i] = next_stim(m_stim[i], md);
    end
    x.inst = i; x.stim = m_stim[i];
    x.armed = ((m_k[i] >= 1) && (m_k[i] >= LAT[i])) ? 1 : 0;
    x.err = m_err[i]; x.cnt = m_cnt[i];
    x.fv = FE_ON ? m_fv[i] : 0;
    x.fe = FE_ON ? m_fe[i] : 0;
    x.fg = FE_ON ? m_fg[i] : 0;
    sbq.push_back(x);
  endtask

  bit prev_r = 1'b0;

  task automatic step(input bit r, input bit e, input bit md, input int inj0, input int inj1);
    int rv0, rv1;
    @(negedge clk);
    rv0 = cur_exp(0) ^ inj0;
    rv1 = cur_exp(1) ^ inj1;
    rst_n = r; en = e; mode = md;
    resp[0] = DW'(rv0);
    resp[1] = DW'(rv1);
    if (!r && prev_r) begin
      // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("async_rst_stim%0d", i), int'(stim_o[i]), 0);
        chk($sformatf("async_rst_armed%0d", i), int'(armed_o[i]), 0);
        chk($sformatf("async_rst_err%0d", i), int'(err_o[i]), 0);
      end
      chk("async_rst_cnt0", int'(cnt_a), 0);
      chk("async_rst_cnt1", int'(cnt_b), 0);
    end
    prev_r = r;
    model_step(0, r, e, md, rv0);
    model_step(1, r, e, md, rv1);
  endtask

  // Monitor: after each rising edge compare every queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk($sformatf("stim%0d", x.inst), int'(stim_o[x.inst]), x.stim);
        chk($sformatf("armed%0d", x.inst), int'(armed_o[x.inst]), x.armed);
        chk($sformatf("err%0d", x.inst), int'(err_o[x.inst]), x.err);
        chk($sformatf("err_cnt%0d", x.inst), (x.inst == 0) ? int'(cnt_a) : int'(cnt_b), x.cnt);
        chk($sformatf("first_vld%0d", x.inst), int'(fv_o[x.inst]), x.fv);
        chk($sformatf("first_exp%0d", x.inst), int'(fe_o[x.inst]), x.fe);
        chk($sformatf("first_got%0d", x.inst), int'(fg_o[x.inst]), x.fg);
      end
    end
  end

  initial begin
    int p;
    resp[0] = '0; resp[1] = '0;
    for (int i = 0; i < 2; i++) begin
      m_stim[i] = 0; m_k[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      m_fv[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
      for (int j = 0; j < 32; j++) hist[i][j] = 0;
    end
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0);
    // LFSR from zero; mismatches injected during warm-up must be ignored.
    for (int c = 0; c < 3; c++) step(1, 1, 1, (c == 0) ? 'h55 : 0, 'h55);
    for (int c = 0; c < 300; c++) step(1, 1, 1, 0, 0);
    // Counter mode from reset, including the FF -> 00 wrap.
    for (int c = 0; c < 2; c++) step(0, 0, 0, 0, 0);
    for (int c = 0; c < 260; c++) step(1, 1, 0, 0, 0);
    // Hold: stimulus frozen, delay line fills with the held value.
    for (int c = 0; c < 5; c++) step(1, 0, 0, 0, 0);
    // One corrupted response on B, then a persistent mismatch to saturate it.
    step(1, 1, 0, 0, 1);
    for (int c = 0; c < 4; c++) step(1, 1, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      p = 1 + $urandom_range(0, 254);
      step(1, 1, 0, 0, p);
    end
    // Randomized en/mode traffic with sporadic errors on A.
    for (int c = 0; c < 200; c++) begin
      p = ($urandom_range(0, 15) == 0) ? (1 + $urandom_range(0, 254)) : 0;
      step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), p, 0);
    end
    // Reset mid-run, then warm-up again.
    for (int c = 0; c < 2; c++) step(0, 1, 0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      p = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), p, p);
    end
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
